// File: rtl/hack_mem_pkg.sv
// Shared types for the Hack data-RAM arbiter: FSM states, response owner
// encoding and the default implemented RAM depth.
package hack_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN_A,
        OWN_B_LOCK
    } arb_state_t;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

    localparam int HACK_RAM_DEPTH = 16384;

endpackage

// File: rtl/hack_ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the Hack data RAM.
// slave = arbiter side, master = requester/RAM side.
interface hack_ram_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic              b_lock;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic              ram_write_enable;
    logic [DATA_W-1:0] ram_data_out;
    logic              oob_err;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_lock, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output ram_address, ram_data_in, ram_write_enable,
        input  ram_data_out,
        output oob_err
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_lock, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_address, ram_data_in, ram_write_enable,
        output ram_data_out,
        input  oob_err
    );

endinterface

// File: rtl/hack_arb_pick.sv
// Combinational two-way chooser: one-hot grant {b, a} from requests,
// FSM state, burst count and the contention tie-break bit.
module hack_arb_pick
    import hack_mem_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int MAX_BURST = 8
) (
    input  logic             a_req,
    input  logic             b_req,
    input  logic             b_lock,
    input  arb_state_t       state,
    input  logic [CNT_W-1:0] burst_cnt,
    input  logic             prio_b,
    output logic [1:0]       gnt,
    output logic             b_cont
);

    logic at_max;
    assign at_max = burst_cnt >= CNT_W'(MAX_BURST);

    always_comb begin
        gnt    = 2'b00;
        b_cont = 1'b0;
        if (state == OWN_B_LOCK && b_req && b_lock) begin
            // burst exhausted with A waiting: A breaks the lock
            if (at_max && a_req) begin
                gnt = 2'b01;
            end else begin
                gnt    = 2'b10;
                b_cont = 1'b1;
            end
        end else begin
            unique case ({a_req, b_req})
                2'b11:   gnt = prio_b ? 2'b10 : 2'b01;
                2'b10:   gnt = 2'b01;
                2'b01:   gnt = 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/hack_ram_arbiter.sv
// Shares the single-port Hack data RAM between CPU (A) and DMA (B).
// HACK_ARB_RR_EN selects round-robin contention; default is A-priority.
module hack_ram_arbiter
    import hack_mem_pkg::*;
#(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 16,
    parameter int RAM_DEPTH = HACK_RAM_DEPTH,
    parameter int MAX_BURST = 8
) (
    input logic               clk,
    input logic               reset,
    hack_ram_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t        state;
    logic [CNT_W-1:0]  burst_cnt;
    logic              prio_b;
    logic              gnt_a;
    logic              gnt_b;
    logic              b_cont;
    logic              any_gnt;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              sel_oob;
    logic [31:0]       addr_ext;
    logic [ADDR_W-1:0] last_addr;
    logic              rd_pend;
    owner_t            rd_owner;
    logic              rd_oob;
    logic              oob_q;

    // reset masks requests so no grant or RAM command leaks out
    hack_arb_pick #(
        .CNT_W     (CNT_W),
        .MAX_BURST (MAX_BURST)
    ) u_pick (
        .a_req     (bus.a_req & ~reset),
        .b_req     (bus.b_req & ~reset),
        .b_lock    (bus.b_lock),
        .state     (state),
        .burst_cnt (burst_cnt),
        .prio_b    (prio_b),
        .gnt       ({gnt_b, gnt_a}),
        .b_cont    (b_cont)
    );

    assign any_gnt   = gnt_a | gnt_b;
    assign sel_addr  = gnt_b ? bus.b_addr  : bus.a_addr;
    assign sel_wdata = gnt_b ? bus.b_wdata : bus.a_wdata;
    assign sel_we    = gnt_b ? bus.b_we    : bus.a_we;
    assign addr_ext  = 32'(sel_addr);
    assign sel_oob   = addr_ext >= 32'(RAM_DEPTH);

    assign bus.a_gnt = gnt_a;
    assign bus.b_gnt = gnt_b;

    assign bus.ram_address      = any_gnt ? sel_addr : last_addr;
    assign bus.ram_data_in      = any_gnt ? sel_wdata : '0;
    assign bus.ram_write_enable = any_gnt & sel_we & ~sel_oob;

    assign bus.a_rvalid = rd_pend & (rd_owner == OWNER_A);
    assign bus.b_rvalid = rd_pend & (rd_owner == OWNER_B);
    assign bus.a_rdata  = (bus.a_rvalid & ~rd_oob) ? bus.ram_data_out : '0;
    assign bus.b_rdata  = (bus.b_rvalid & ~rd_oob) ? bus.ram_data_out : '0;
    assign bus.oob_err  = oob_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend   <= 1'b0;
            rd_owner  <= OWNER_A;
            rd_oob    <= 1'b0;
            oob_q     <= 1'b0;
            last_addr <= '0;
        end else begin
            rd_pend  <= any_gnt & ~sel_we;
            rd_owner <= gnt_b ? OWNER_B : OWNER_A;
            rd_oob   <= sel_oob;
            oob_q    <= any_gnt & sel_oob;
            if (any_gnt) begin
                last_addr <= sel_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            burst_cnt <= '0;
        end else if (gnt_b && bus.b_lock) begin
            state <= OWN_B_LOCK;
            if (!b_cont) begin
                burst_cnt <= CNT_W'(1);
            end else if (burst_cnt < CNT_W'(MAX_BURST)) begin
                burst_cnt <= burst_cnt + CNT_W'(1);
            end
        end else if (gnt_a) begin
            state     <= OWN_A;
            burst_cnt <= '0;
        end else begin
            state     <= IDLE;
            burst_cnt <= '0;
        end
    end

`ifdef HACK_ARB_RR_EN
    // last winner: after an A grant, B wins the next contention
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_b <= 1'b0;
        end else if (any_gnt) begin
            prio_b <= gnt_a;
        end
    end
`else
    assign prio_b = 1'b0;
`endif

endmodule
